// File: rtl/apb_bridge_pkg.sv
// Shared types and field layout for the AHB-to-APB bridge, APB side.
// Optional timeout feature of apb_cmd_master is enabled by defining APB_TIMEOUT_EN.
package apb_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    RESP   = 3'd4
  } state_e;

  localparam int unsigned CMD_DATA_LSB = 0;

  // Remaining field positions scale with the instance widths.
  function automatic int unsigned CMD_ADDR_LSB(input int unsigned data_w);
    return data_w;
  endfunction

  function automatic int unsigned CMD_WR_BIT(input int unsigned addr_w, input int unsigned data_w);
    return addr_w + data_w;
  endfunction

  function automatic int unsigned RESP_ERR_BIT(input int unsigned data_w);
    return data_w;
  endfunction

  localparam logic [255:0] TIMEOUT_DATA = '1;

endpackage

// File: rtl/apb_cmd_master.sv
// Pops command words, runs one APB3 transfer each, pushes {slverr, data} responses.
// Define APB_TIMEOUT_EN to add the ACCESS wait limit and the timeout_err output.
module apb_cmd_master
  import apb_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned CMD_W          = 1 + ADDR_WIDTH + DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  rclk,
  input  logic                  reset,
  output logic                  cmd_ren,
  input  logic [CMD_W-1:0]      cmd_rdata,
  input  logic                  cmd_empty,
  output logic                  resp_wen,
  output logic [DATA_WIDTH:0]   resp_wdata,
  input  logic                  resp_full,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr,
`ifdef APB_TIMEOUT_EN
  output logic                  timeout_err,
`endif
  output logic                  busy,
  output logic [15:0]           xfer_count
);

  localparam int unsigned WR_BIT   = CMD_WR_BIT(ADDR_WIDTH, DATA_WIDTH);
  localparam int unsigned ADDR_LSB = CMD_ADDR_LSB(DATA_WIDTH);
  localparam int unsigned ERR_BIT  = RESP_ERR_BIT(DATA_WIDTH);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [DATA_WIDTH:0]   resp_q, resp_d;
  logic [15:0]           xfer_q, xfer_d;
  logic [DATA_WIDTH-1:0] rdata_sel;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wait_q, wait_d;
  logic            to_q, to_d;
`endif

  always_ff @(posedge rclk) begin
    if (reset) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      resp_q   <= '0;
      xfer_q   <= '0;
`ifdef APB_TIMEOUT_EN
      wait_q   <= '0;
      to_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      resp_q   <= resp_d;
      xfer_q   <= xfer_d;
`ifdef APB_TIMEOUT_EN
      wait_q   <= wait_d;
      to_q     <= to_d;
`endif
    end
  end

  assign rdata_sel = pwrite_q ? '0 : prdata;

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    resp_d   = resp_q;
    xfer_d   = xfer_q;
`ifdef APB_TIMEOUT_EN
    wait_d   = wait_q;
    to_d     = to_q;
`endif
    case (state_q)
      // Response slot is checked before popping, so a popped command always has room.
      IDLE:  if (!cmd_empty && !resp_full) state_d = FETCH;
      FETCH: begin
        paddr_d  = cmd_rdata[ADDR_LSB +: ADDR_WIDTH];
        pwrite_d = cmd_rdata[WR_BIT];
        pwdata_d = cmd_rdata[CMD_DATA_LSB +: DATA_WIDTH];
        state_d  = SETUP;
      end
      SETUP: begin
`ifdef APB_TIMEOUT_EN
        wait_d = '0;
        to_d   = 1'b0;
`endif
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          resp_d          = '0;
          resp_d[ERR_BIT] = pslverr;
          resp_d[DATA_WIDTH-1:0] = rdata_sel;
          state_d         = RESP;
        end
`ifdef APB_TIMEOUT_EN
        else if (wait_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          resp_d          = '0;
          resp_d[ERR_BIT] = 1'b1;
          resp_d[DATA_WIDTH-1:0] = TIMEOUT_DATA[DATA_WIDTH-1:0];
          to_d            = 1'b1;
          state_d         = RESP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
`endif
      end
      RESP: begin
        xfer_d  = xfer_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ren  = (state_q == IDLE) && !cmd_empty && !resp_full;
    resp_wen = (state_q == RESP);
    psel     = (state_q == SETUP) || (state_q == ACCESS);
    penable  = (state_q == ACCESS);
    busy     = (state_q != IDLE);
`ifdef APB_TIMEOUT_EN
    timeout_err = (state_q == RESP) && to_q;
`endif
  end

  assign paddr      = paddr_q;
  assign pwrite     = pwrite_q;
  assign pwdata     = pwdata_q;
  assign resp_wdata = resp_q;
  assign xfer_count = xfer_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: directed table, multi-cycle corner sequences, random traffic.
module tb_apb_cmd_master;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 1 + AW + DW;
`ifdef APB_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 256;
`endif

  logic          rclk = 1'b0;
  logic          reset;
  logic          cmd_ren;
  logic [CW-1:0] cmd_rdata;
  logic          cmd_empty;
  logic          resp_wen;
  logic [DW:0]   resp_wdata;
  logic          resp_full;
  logic [AW-1:0] paddr;
  logic          psel, penable, pwrite;
  logic [DW-1:0] pwdata, prdata;
  logic          pready, pslverr;
  logic          busy;
  logic [15:0]   xfer_count;
`ifdef APB_TIMEOUT_EN
  logic          timeout_err;
`endif

  apb_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .rclk(rclk), .reset(reset), .cmd_ren(cmd_ren), .cmd_rdata(cmd_rdata),
    .cmd_empty(cmd_empty), .resp_wen(resp_wen), .resp_wdata(resp_wdata),
    .resp_full(resp_full), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr),
`ifdef APB_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .busy(busy), .xfer_count(xfer_count)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int unsigned waits;
    logic [31:0] rdata;
    logic        err;
    logic [32:0] exp_resp;
    int unsigned exp_lat;
    int unsigned exp_acc;
  } vec_t;

  typedef struct {
    int unsigned waits;
    logic [31:0] rdata;
    logic        err;
  } plan_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [32:0] resp;
    int unsigned lat;
    int unsigned acc;
    int          ren_cyc;
  } exp_t;

  int unsigned   total = 0, passed = 0;
  int            cyc = 0, last_ren = 0, ntx = 0, to_pulses = 0;
  bit            have_last = 0, have_inf = 0, setup_seen = 0;
  int unsigned   acc_cnt = 0, wcnt = 0;
  logic [CW-1:0] fifo_q[$];
  plan_t         plan_q[$];
  exp_t          exp_q[$];
  exp_t          inflight;
  plan_t         cur_plan;
  vec_t          tbl[5];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference behaviour: writes return zero data, reads return the slave data; error bit on top.
  function automatic logic [32:0] model_resp(input logic wr, input logic [31:0] rd, input logic err);
    return {err, wr ? 32'h0 : rd};
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.wr       = 1'($urandom_range(0, 1));
    v.addr     = $urandom;
    v.wdata    = $urandom;
    v.waits    = $urandom_range(0, 3);
    v.rdata    = $urandom;
    v.err      = ($urandom_range(0, 3) == 0);
    v.exp_resp = model_resp(v.wr, v.rdata, v.err);
    v.exp_lat  = 4 + v.waits;
    v.exp_acc  = v.waits + 1;
    return v;
  endfunction

  task automatic issue(input vec_t v);
    exp_t e;
    fifo_q.push_back({v.wr, v.addr, v.wdata});
    cmd_empty = 1'b0;
    plan_q.push_back('{v.waits, v.rdata, v.err});
    e.wr = v.wr; e.addr = v.addr; e.wdata = v.wdata; e.resp = v.exp_resp;
    e.lat = v.exp_lat; e.acc = v.exp_acc; e.ren_cyc = 0;
    exp_q.push_back(e);
  endtask

  task automatic cycle();
    bit ren, wen;
    #1;
    ren = cmd_ren;
    wen = resp_wen;
    if (ren) begin
      check("ren_only_in_idle", busy, 0);
      if (exp_q.size() == 0) check("ren_unexpected", 1, 0);
      else begin
        if (have_last) check("ren_gap_ge5", (cyc - last_ren) >= 5, 1);
        inflight = exp_q.pop_front();
        inflight.ren_cyc = cyc;
        have_inf = 1; acc_cnt = 0; setup_seen = 0;
        last_ren = cyc; have_last = 1;
      end
    end
    if (psel && !penable) setup_seen = 1;
    if (psel && penable && have_inf) begin
      acc_cnt++;
      check("access_bus_stable", {paddr, pwrite, pwdata}, {inflight.addr, inflight.wr, inflight.wdata});
    end
`ifdef APB_TIMEOUT_EN
    if (timeout_err) begin
      to_pulses++;
      check("timeout_err_with_wen", wen, 1);
    end
`endif
    if (wen) begin
      if (!have_inf) check("wen_unexpected", 1, 0);
      else begin
        check("resp_wdata", resp_wdata, inflight.resp);
        check("resp_latency", cyc - inflight.ren_cyc, inflight.lat);
        check("access_cycles", acc_cnt, inflight.acc);
        check("setup_phase", setup_seen, 1);
        have_inf = 0;
        ntx++;
      end
    end
    @(posedge rclk);
    #1;
    cyc++;
    if (wen) check("xfer_count", xfer_count, 16'(ntx));
    if (ren && fifo_q.size() > 0) cmd_rdata = fifo_q.pop_front();
    else cmd_rdata = CW'({$urandom, $urandom, $urandom});
    cmd_empty = (fifo_q.size() == 0);
    if (psel && !penable && plan_q.size() > 0) begin
      cur_plan = plan_q.pop_front();
      wcnt = cur_plan.waits;
    end
    if (psel && penable) begin
      pready = (wcnt == 0);
      if (wcnt != 0) wcnt--;
      prdata  = pready ? cur_plan.rdata : $urandom;
      pslverr = pready ? cur_plan.err : 1'($urandom);
    end else begin
      pready  = 1'($urandom);
      prdata  = $urandom;
      pslverr = 1'($urandom);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    do begin
      cycle();
      n++;
    end while ((exp_q.size() > 0 || have_inf) && n < budget);
    if (exp_q.size() > 0 || have_inf) begin
      check("drain_budget", 0, 1);
      exp_q.delete(); plan_q.delete(); fifo_q.delete();
      have_inf = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int base;
    vec_t v;
    tbl[0] = '{1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 0, 32'h5A5A_5A5A, 1'b0, 33'h0_0000_0000, 4, 1};
    tbl[1] = '{1'b0, 32'h0000_2004, 32'h0000_0000, 3, 32'h1234_5678, 1'b0, 33'h0_1234_5678, 7, 4};
    tbl[2] = '{1'b0, 32'h0000_3008, 32'h1111_2222, 0, 32'hAAAA_5555, 1'b1, 33'h1_AAAA_5555, 4, 1};
    tbl[3] = '{1'b1, 32'h0000_400C, 32'h0BAD_F00D, 2, 32'hFFFF_FFFF, 1'b1, 33'h1_0000_0000, 6, 3};
    tbl[4] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 1, 32'h0000_0001, 1'b0, 33'h0_0000_0001, 5, 2};

    reset = 1'b1; cmd_empty = 1'b1; resp_full = 1'b0; cmd_rdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (3) cycle();
    reset = 1'b0;
    #1;
    check("reset_ctrl", {cmd_ren, resp_wen, psel, penable, pwrite, busy}, 0);
    check("reset_data", {paddr, pwdata}, 0);
    check("reset_resp", resp_wdata, 0);
    check("reset_xfer_count", xfer_count, 0);

    for (int i = 0; i < 5; i++) begin
      issue(tbl[i]);
      drain(60);
    end

    // Back-pressure: a queued command must wait while the response FIFO is full.
    resp_full = 1'b1;
    issue(tbl[0]);
    repeat (10) begin
      #1;
      check("bp_no_ren", cmd_ren, 0);
      check("bp_no_psel", psel, 0);
      cycle();
    end
    resp_full = 1'b0;
    #1;
    check("bp_release_ren", cmd_ren, 1);
    drain(60);

    base = ntx;
    for (int i = 1; i < 4; i++) issue(tbl[i]);
    drain(120);
    check("b2b_xfer_count", xfer_count, 16'(base + 3));

    // Reset while ACCESS is stretched by a stalled slave.
    v = tbl[1];
    v.waits = 50;
    issue(v);
    n = 0;
    while (!(psel && penable) && n < 20) begin
      cycle();
      n++;
    end
    check("reached_access", psel && penable, 1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    have_inf = 0; exp_q.delete(); plan_q.delete(); wcnt = 0; ntx = 0;
    #1;
    check("rst_mid_psel", psel, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_wen", resp_wen, 0);
    check("rst_mid_xfer", xfer_count, 0);
    repeat (4) cycle();
    issue(tbl[2]);
    drain(60);

    for (int it = 0; it < 30; it++) begin
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) issue(rand_vec());
      drain(150);
      repeat ($urandom_range(0, 2)) cycle();
    end

`ifdef APB_TIMEOUT_EN
    v = tbl[1];
    v.waits = 100;
    v.exp_resp = {1'b1, 32'hFFFF_FFFF};
    v.exp_lat = 3 + TO;
    v.exp_acc = TO;
    to_pulses = 0;
    issue(v);
    drain(60);
    repeat (3) cycle();
    check("timeout_pulses", to_pulses, 1);
    issue(tbl[0]);
    drain(60);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
